decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Parametrised ID stage: instruction queue (IQ_DEPTH entries of {pc,instr}) between fetch and execute,
//  decode of the head entry into rv32i_control_word plus M-extension and illegal-instruction flags,
//  registered output with valid/ready handshake. Supplies decoded ops to EX; flush from branch resolution.
// PARAMETERS
//  IQ_DEPTH  4  queue entries, power of two, >=2
//  EN_MEXT   1  1: decode funct7=7'b0000001 in op_reg as MUL/DIV; 0: such encodings are illegal
// PORTS
//  clk          in   1    clock
//  rst          in   1    synchronous active-high reset
//  flush        in   1    discard queue and output register
//  in_valid     in   1    fetch offers instruction
//  in_ready     out  1    queue can accept (= count < IQ_DEPTH)
//  in_pc        in   32   pc of offered instruction
//  in_instr     in   32   instruction word
//  out_valid    out  1    out_* hold a decoded instruction
//  out_ready    in   1    EX accepts
//  out_pc       out  32   pc of decoded instruction
//  out_ctrl     out  $bits(rv32i_control_word)  control word
//  out_rs1/out_rs2/out_rd  out  5 each  register indices (instr[19:15],[24:20],[11:7])
//  out_muldiv   out  1    M-extension op; funct3 in out_ctrl selects mul/mulh/mulhsu/mulhu/div/divu/rem/remu
//  out_illegal  out  1    encoding not supported
//  count        out  $clog2(IQ_DEPTH+1)  queue occupancy
// BEHAVIOUR
//  Reset (rst=1 at edge): queue empty, count=0, out_valid=0, out_illegal=0, out_muldiv=0, out_pc=0, out_ctrl=defaults.
//  Enqueue when in_valid&&in_ready; no enqueue when full even if output advances same cycle.
//  Output reg loads head when queue non-empty && (!out_valid || out_ready); head dequeued same edge.
//  Latency: instruction enqueued at edge t, empty queue, idle output -> out_valid=1 after edge t+1.
//  Simultaneous enq+deq: count unchanged; pointers wrap modulo IQ_DEPTH.
//  out_valid&&!out_ready: out_* held stable; queue fills; in_ready drops when count==IQ_DEPTH.
//  flush (rst takes priority): next edge queue empty, out_valid=0; in_valid during flush cycle dropped.
//  Decode defaults: pcmux=pc_plus4, alumux1=rs1_out, alumux2=i_imm, regfilemux=alu_out, cmpmux=rs2_out,
//   marmux=pc_out, aluop=alu_add, cmpop=beq, load_regfile/mem_read/mem_write=0.
//  lui/auipc/jal/jalr/br/load/store/imm/reg decoded per RV32I; slt/sltu via comparator, regfilemux=br_en.
//  Illegal: unknown opcode; branch funct3 010/011; load funct3 011/110/111; store funct3>010;
//   op_imm slli funct7!=0, srli/srai funct7 not in {0,0x20}; op_reg funct7 not 0,
//   or 0x20 with funct3 not add/sr, or 0x01 with EN_MEXT=0. Illegal -> defaults with write/read enables
//   all 0, out_illegal=1, out_muldiv=0.
//  out_rd==0 forces load_regfile=0 (all opcodes); mem_read still asserted for loads to x0.
//  EN_MEXT && op_reg && funct7==0x01: out_muldiv=1, load_regfile=1 (unless rd==0), aluop unchanged default.
// STRUCTURE
//  rv32i_types: add arith_funct7_t constants (base=7'h00, alt=7'h20, muldiv=7'h01), muldiv_funct3_t enum.
//  Sub-module instr_decoder: purely combinational {instr} -> {ctrl, muldiv, illegal}, param EN_MEXT.
//  Queue: circular buffer, wr/rd pointers + count register, inside decode_stage.
// TESTING
//  Reset, then in 0x00500093 (addi x1,x0,5) pc 0x60 -> 2 edges later out_valid, load_regfile=1, aluop=alu_add, out_pc=0x60.
//  out_ready=0, feed 6 addi back-to-back, IQ_DEPTH=4 -> count=4, in_ready=0, out_* stable; release -> 5 emitted in order.
//  0x02208033 (mul x0,x1,x2) EN_MEXT=1 -> out_muldiv=1, load_regfile=0; EN_MEXT=0 -> out_illegal=1.
//  0xFFFFFFFF and 0x0000B003 (ld) -> out_illegal=1, mem_read=0, mem_write=0, load_regfile=0.
//  Queue holds 3, out_valid=1, assert flush with in_valid=1 -> next cycle count=0, out_valid=0, dropped instr never emitted.
//  Continuous enq/deq for 3*IQ_DEPTH instructions with out_ready=1 -> pointer wrap, count constant, sequence preserved.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode types: opcodes, funct encodings, datapath mux selects and the control word.
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } branch_funct3_t;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef enum logic [2:0] {
    add  = 3'b000,
    sll  = 3'b001,
    slt  = 3'b010,
    sltu = 3'b011,
    axor = 3'b100,
    sr   = 3'b101,
    aor  = 3'b110,
    aand = 3'b111
  } arith_funct3_t;

  typedef enum logic [6:0] {
    funct7_base   = 7'h00,
    funct7_alt    = 7'h20,
    funct7_muldiv = 7'h01
  } arith_funct7_t;

  typedef enum logic [2:0] {
    md_mul    = 3'b000,
    md_mulh   = 3'b001,
    md_mulhsu = 3'b010,
    md_mulhu  = 3'b011,
    md_div    = 3'b100,
    md_divu   = 3'b101,
    md_rem    = 3'b110,
    md_remu   = 3'b111
  } muldiv_funct3_t;

  // ALU op encodings line up with arith funct3 except sra/sub, which reuse the slt slots.
  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops;

  typedef enum logic [1:0] {
    pcmux_pc_plus4 = 2'b00,
    pcmux_alu_out  = 2'b01,
    pcmux_alu_mod2 = 2'b10
  } pcmux_sel_t;

  typedef enum logic {
    alumux1_rs1_out = 1'b0,
    alumux1_pc_out  = 1'b1
  } alumux1_sel_t;

  typedef enum logic [2:0] {
    alumux2_i_imm   = 3'd0,
    alumux2_u_imm   = 3'd1,
    alumux2_b_imm   = 3'd2,
    alumux2_s_imm   = 3'd3,
    alumux2_j_imm   = 3'd4,
    alumux2_rs2_out = 3'd5
  } alumux2_sel_t;

  typedef enum logic [3:0] {
    regfilemux_alu_out  = 4'd0,
    regfilemux_br_en    = 4'd1,
    regfilemux_u_imm    = 4'd2,
    regfilemux_lw       = 4'd3,
    regfilemux_pc_plus4 = 4'd4,
    regfilemux_lb       = 4'd5,
    regfilemux_lbu      = 4'd6,
    regfilemux_lh       = 4'd7,
    regfilemux_lhu      = 4'd8
  } regfilemux_sel_t;

  typedef enum logic {
    cmpmux_rs2_out = 1'b0,
    cmpmux_i_imm   = 1'b1
  } cmpmux_sel_t;

  typedef enum logic {
    marmux_pc_out  = 1'b0,
    marmux_alu_out = 1'b1
  } marmux_sel_t;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    alu_ops          aluop;
    branch_funct3_t  cmpop;
    pcmux_sel_t      pcmux;
    alumux1_sel_t    alumux1;
    alumux2_sel_t    alumux2;
    regfilemux_sel_t regfilemux;
    cmpmux_sel_t     cmpmux;
    marmux_sel_t     marmux;
    logic            load_regfile;
    logic            mem_read;
    logic            mem_write;
  } rv32i_control_word;

  function automatic rv32i_control_word default_ctrl();
    rv32i_control_word c;
    c.opcode       = '0;
    c.funct3       = '0;
    c.aluop        = alu_add;
    c.cmpop        = beq;
    c.pcmux        = pcmux_pc_plus4;
    c.alumux1      = alumux1_rs1_out;
    c.alumux2      = alumux2_i_imm;
    c.regfilemux   = regfilemux_alu_out;
    c.cmpmux       = cmpmux_rs2_out;
    c.marmux       = marmux_pc_out;
    c.load_regfile = 1'b0;
    c.mem_read     = 1'b0;
    c.mem_write    = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/decode_stage_instr_decoder.sv
// Combinational RV32I(+M) decoder: one instruction word to control word, mul/div and illegal flags.
module instr_decoder
  import rv32i_types::*;
#(
  parameter bit EN_MEXT = 1'b1
) (
  input  logic [31:0]       instr,
  output rv32i_control_word ctrl,
  output logic              muldiv,
  output logic              illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic       unused_regs;

  assign opcode      = instr[6:0];
  assign funct3      = instr[14:12];
  assign funct7      = instr[31:25];
  assign rd          = instr[11:7];
  assign unused_regs = ^instr[24:15];

  always_comb begin
    ctrl        = default_ctrl();
    muldiv      = 1'b0;
    illegal     = 1'b0;
    ctrl.opcode = opcode;
    ctrl.funct3 = funct3;

    case (opcode)
      op_lui: begin
        ctrl.load_regfile = 1'b1;
        ctrl.regfilemux   = regfilemux_u_imm;
      end
      op_auipc: begin
        ctrl.load_regfile = 1'b1;
        ctrl.alumux1      = alumux1_pc_out;
        ctrl.alumux2      = alumux2_u_imm;
      end
      op_jal: begin
        ctrl.load_regfile = 1'b1;
        ctrl.pcmux        = pcmux_alu_out;
        ctrl.alumux1      = alumux1_pc_out;
        ctrl.alumux2      = alumux2_j_imm;
        ctrl.regfilemux   = regfilemux_pc_plus4;
      end
      op_jalr: begin
        ctrl.load_regfile = 1'b1;
        ctrl.pcmux        = pcmux_alu_mod2;
        ctrl.regfilemux   = regfilemux_pc_plus4;
      end
      op_br: begin
        if (funct3 == 3'b010 || funct3 == 3'b011) begin
          illegal = 1'b1;
        end else begin
          ctrl.cmpop   = branch_funct3_t'(funct3);
          ctrl.alumux1 = alumux1_pc_out;
          ctrl.alumux2 = alumux2_b_imm;
        end
      end
      op_load: begin
        ctrl.mem_read     = 1'b1;
        ctrl.load_regfile = 1'b1;
        ctrl.marmux       = marmux_alu_out;
        case (funct3)
          lb:      ctrl.regfilemux = regfilemux_lb;
          lh:      ctrl.regfilemux = regfilemux_lh;
          lw:      ctrl.regfilemux = regfilemux_lw;
          lbu:     ctrl.regfilemux = regfilemux_lbu;
          lhu:     ctrl.regfilemux = regfilemux_lhu;
          default: illegal = 1'b1;
        endcase
      end
      op_store: begin
        if (funct3 > sw) begin
          illegal = 1'b1;
        end else begin
          ctrl.mem_write = 1'b1;
          ctrl.alumux2   = alumux2_s_imm;
          ctrl.marmux    = marmux_alu_out;
        end
      end
      op_imm: begin
        ctrl.load_regfile = 1'b1;
        case (funct3)
          slt: begin
            ctrl.cmpop      = blt;
            ctrl.cmpmux     = cmpmux_i_imm;
            ctrl.regfilemux = regfilemux_br_en;
          end
          sltu: begin
            ctrl.cmpop      = bltu;
            ctrl.cmpmux     = cmpmux_i_imm;
            ctrl.regfilemux = regfilemux_br_en;
          end
          sll: begin
            if (funct7 != funct7_base) illegal = 1'b1;
            ctrl.aluop = alu_sll;
          end
          sr: begin
            if (funct7 == funct7_base)     ctrl.aluop = alu_srl;
            else if (funct7 == funct7_alt) ctrl.aluop = alu_sra;
            else                           illegal = 1'b1;
          end
          default: ctrl.aluop = alu_ops'(funct3);
        endcase
      end
      op_reg: begin
        ctrl.load_regfile = 1'b1;
        ctrl.alumux2      = alumux2_rs2_out;
        case (funct7)
          funct7_base: begin
            case (funct3)
              slt: begin
                ctrl.cmpop      = blt;
                ctrl.regfilemux = regfilemux_br_en;
              end
              sltu: begin
                ctrl.cmpop      = bltu;
                ctrl.regfilemux = regfilemux_br_en;
              end
              default: ctrl.aluop = alu_ops'(funct3);
            endcase
          end
          funct7_alt: begin
            if (funct3 == add)     ctrl.aluop = alu_sub;
            else if (funct3 == sr) ctrl.aluop = alu_sra;
            else                   illegal = 1'b1;
          end
          funct7_muldiv: begin
            if (EN_MEXT) muldiv = 1'b1;
            else         illegal = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      ctrl   = default_ctrl();
      muldiv = 1'b0;
    end
    if (rd == 5'd0) ctrl.load_regfile = 1'b0;
  end

endmodule

// File: rtl/decode_stage.sv
// ID stage: circular instruction queue feeding a decoder and a registered valid/ready output slot.
module decode_stage
  import rv32i_types::*;
#(
  parameter int unsigned IQ_DEPTH = 4,
  parameter bit          EN_MEXT  = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [31:0]                   in_pc,
  input  logic [31:0]                   in_instr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_pc,
  output rv32i_control_word             out_ctrl,
  output logic [4:0]                    out_rs1,
  output logic [4:0]                    out_rs2,
  output logic [4:0]                    out_rd,
  output logic                          out_muldiv,
  output logic                          out_illegal,
  output logic [$clog2(IQ_DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(IQ_DEPTH);
  localparam int unsigned CW = $clog2(IQ_DEPTH + 1);

  logic [31:0]       pc_mem_q    [IQ_DEPTH];
  logic [31:0]       instr_mem_q [IQ_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              enq, deq;

  logic              out_valid_q;
  logic [31:0]       out_pc_q;
  rv32i_control_word out_ctrl_q;
  logic [4:0]        out_rs1_q, out_rs2_q, out_rd_q;
  logic              out_muldiv_q, out_illegal_q;

  logic [31:0]       head_pc, head_instr;
  rv32i_control_word dec_ctrl;
  logic              dec_muldiv, dec_illegal;

  assign head_pc    = pc_mem_q[rd_ptr_q];
  assign head_instr = instr_mem_q[rd_ptr_q];

  instr_decoder #(.EN_MEXT(EN_MEXT)) u_dec (
    .instr   (head_instr),
    .ctrl    (dec_ctrl),
    .muldiv  (dec_muldiv),
    .illegal (dec_illegal)
  );

  // Full blocks enqueue even if the output drains this cycle, so in_ready depends only on count.
  always_comb begin
    in_ready = (count_q < CW'(IQ_DEPTH));
    enq      = in_valid && in_ready && !flush;
    deq      = (count_q != '0) && (!out_valid_q || out_ready) && !flush;
    wr_ptr_d = enq ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = deq ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem_q[wr_ptr_q]    <= in_pc;
      instr_mem_q[wr_ptr_q] <= in_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      out_valid_q   <= 1'b0;
      out_pc_q      <= '0;
      out_ctrl_q    <= default_ctrl();
      out_rs1_q     <= '0;
      out_rs2_q     <= '0;
      out_rd_q      <= '0;
      out_muldiv_q  <= 1'b0;
      out_illegal_q <= 1'b0;
    end else if (flush) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (deq) begin
        out_valid_q   <= 1'b1;
        out_pc_q      <= head_pc;
        out_ctrl_q    <= dec_ctrl;
        out_rs1_q     <= head_instr[19:15];
        out_rs2_q     <= head_instr[24:20];
        out_rd_q      <= head_instr[11:7];
        out_muldiv_q  <= dec_muldiv;
        out_illegal_q <= dec_illegal;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_pc_q;
  assign out_ctrl    = out_ctrl_q;
  assign out_rs1     = out_rs1_q;
  assign out_rs2     = out_rs2_q;
  assign out_rd      = out_rd_q;
  assign out_muldiv  = out_muldiv_q;
  assign out_illegal = out_illegal_q;
  assign count       = count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with an expected-result queue filled on accepted input.
module tb_decode_stage;
  import rv32i_types::*;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, out_ready;
  logic              in_ready, out_valid, out_muldiv, out_illegal;
  logic [31:0]       in_pc, in_instr, out_pc;
  rv32i_control_word out_ctrl;
  logic [4:0]        out_rs1, out_rs2, out_rd;
  logic [2:0]        count;

  logic              n_in_valid, n_in_ready, n_out_valid, n_out_muldiv, n_out_illegal;
  logic [31:0]       n_out_pc;
  rv32i_control_word n_out_ctrl;
  logic [4:0]        n_out_rs1, n_out_rs2, n_out_rd;
  logic [2:0]        n_count;

  always #5 clk = ~clk;

  decode_stage #(.IQ_DEPTH(4), .EN_MEXT(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_ctrl(out_ctrl),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_muldiv(out_muldiv), .out_illegal(out_illegal), .count(count)
  );

  decode_stage #(.IQ_DEPTH(4), .EN_MEXT(1'b0)) dut_nom (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_pc(32'h0000_0200), .in_instr(32'h0220_8033),
    .out_valid(n_out_valid), .out_ready(1'b0), .out_pc(n_out_pc), .out_ctrl(n_out_ctrl),
    .out_rs1(n_out_rs1), .out_rs2(n_out_rs2), .out_rd(n_out_rd),
    .out_muldiv(n_out_muldiv), .out_illegal(n_out_illegal), .count(n_count)
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        ill, md, lr, mr, mw;
    alu_ops      aluop;
  } exp_t;

  exp_t sb[$];
  exp_t nxt;
  int unsigned checks  = 0;
  int unsigned errors  = 0;
  int unsigned emitted = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with inputs set; accounts for the transfers the next rising edge performs.
  task automatic tick();
    exp_t e;
    if (!flush && out_valid && out_ready) begin
      chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        emitted++;
        chk("out_pc", out_pc, e.pc);
        chk("out_rd", out_rd, e.rd);
        chk("out_illegal", out_illegal, e.ill);
        chk("out_muldiv", out_muldiv, e.md);
        chk("load_regfile", out_ctrl.load_regfile, e.lr);
        chk("mem_read", out_ctrl.mem_read, e.mr);
        chk("mem_write", out_ctrl.mem_write, e.mw);
        chk("aluop", out_ctrl.aluop, e.aluop);
      end
    end
    if (!flush && in_valid && in_ready) sb.push_back(nxt);
    if (flush) sb.delete();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] instr,
                       input logic ill, input logic md, input logic lr,
                       input logic mr, input logic mw, input alu_ops aop);
    logic [31:0] w;
    w         = instr;
    in_valid  = 1'b1;
    in_pc     = pc;
    in_instr  = instr;
    nxt.pc    = pc;
    nxt.rd    = w[11:7];
    nxt.ill   = ill;
    nxt.md    = md;
    nxt.lr    = lr;
    nxt.mr    = mr;
    nxt.mw    = mw;
    nxt.aluop = aop;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (sb.size() != 0 || out_valid); i++) tick();
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  rv32i_control_word dflt;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0; n_in_valid = 1'b0;
    dflt = '0;
    dflt.aluop = alu_add; dflt.cmpop = beq; dflt.pcmux = pcmux_pc_plus4;
    dflt.alumux1 = alumux1_rs1_out; dflt.alumux2 = alumux2_i_imm;
    dflt.regfilemux = regfilemux_alu_out; dflt.cmpmux = cmpmux_rs2_out;
    dflt.marmux = marmux_pc_out;
    repeat (3) @(negedge clk);

    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_illegal", out_illegal, 0);
    chk("rst_muldiv", out_muldiv, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_ctrl", out_ctrl, dflt);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    // addi x1,x0,5: visible two edges after being offered
    offer(32'h60, 32'h0050_0093, 0, 0, 1, 0, 0, alu_add);
    tick();
    in_valid = 1'b0;
    chk("lat_not_yet", out_valid, 0);
    chk("lat_count1", count, 1);
    tick();
    chk("lat_valid", out_valid, 1);
    chk("lat_pc", out_pc, 32'h60);
    chk("lat_lr", out_ctrl.load_regfile, 1);
    chk("lat_rs1", out_rs1, 0);
    out_ready = 1'b1;
    drain();

    // back-pressure: six offered, queue of four plus the output slot hold five
    out_ready = 1'b0;
    emitted   = 0;
    for (int i = 0; i < 6; i++) begin
      offer(32'h100 + 32'(4 * i), 32'h0050_0093 | (32'(i + 1) << 7), 0, 0, 1, 0, 0, alu_add);
      tick();
    end
    in_valid = 1'b0;
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    chk("stall_valid", out_valid, 1);
    chk("stall_pc", out_pc, 32'h100);
    tick();
    tick();
    chk("stall_pc_hold", out_pc, 32'h100);
    chk("stall_rd_hold", out_rd, 1);
    out_ready = 1'b1;
    drain();
    chk("stall_emitted", emitted, 5);

    // M-extension, illegal and memory encodings
    n_in_valid = 1'b1;
    offer(32'h200, 32'h0220_8033, 0, 1, 0, 0, 0, alu_add); tick();
    n_in_valid = 1'b0;
    offer(32'h204, 32'h0220_81B3, 0, 1, 1, 0, 0, alu_add); tick();
    offer(32'h208, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, alu_add); tick();
    offer(32'h20C, 32'h0000_B003, 1, 0, 0, 0, 0, alu_add); tick();
    offer(32'h210, 32'h0000_A103, 0, 0, 1, 1, 0, alu_add); tick();
    offer(32'h214, 32'h0000_A003, 0, 0, 0, 1, 0, alu_add); tick();
    offer(32'h218, 32'h0020_A023, 0, 0, 0, 0, 1, alu_add); tick();
    offer(32'h21C, 32'h4020_82B3, 0, 0, 1, 0, 0, alu_sub); tick();
    in_valid = 1'b0;
    drain();
    for (int i = 0; i < 8 && !n_out_valid; i++) tick();
    chk("nom_valid", n_out_valid, 1);
    chk("nom_illegal", n_out_illegal, 1);
    chk("nom_muldiv", n_out_muldiv, 0);
    chk("nom_lr", n_out_ctrl.load_regfile, 0);

    // flush with queue holding three and output valid
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      offer(32'h300 + 32'(4 * i), 32'h0050_0093 | (32'(i + 1) << 7), 0, 0, 1, 0, 0, alu_add);
      tick();
    end
    chk("pre_flush_count", count, 3);
    chk("pre_flush_valid", out_valid, 1);
    flush = 1'b1;
    offer(32'hDEAD0, 32'h0050_0093, 0, 0, 1, 0, 0, alu_add);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_valid", out_valid, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("flush_no_emit", out_valid, 0);
    end

    // streaming through the pointer wrap
    emitted = 0;
    for (int i = 0; i < 12; i++) begin
      offer(32'h400 + 32'(4 * i), 32'h0050_0093 | (32'(i % 31 + 1) << 7), 0, 0, 1, 0, 0, alu_add);
      tick();
      chk("stream_count", count, 1);
    end
    in_valid = 1'b0;
    drain();
    chk("stream_emitted", emitted, 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
